// File: rtl/xer_cr_wb.sv
// xer_cr_wb: architectural XER(SO,OV,CA) and CR holder fed through a 1-entry flushable commit stage
module xer_cr_wb #(
  parameter int ARCH_WIDTH = 32,
  parameter int CRF_NUM    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ca_we,
  input  logic                       ca_in,
  input  logic                       ov_we,
  input  logic                       ov_in,
  input  logic                       cr_we,
  input  logic [$clog2(CRF_NUM)-1:0] cr_fld,
  input  logic [3:0]                 cr_val,
  input  logic                       mtcrf_we,
  input  logic [CRF_NUM-1:0]         mtcrf_fxm,
  input  logic [ARCH_WIDTH-1:0]      mtcrf_din,
  input  logic                       mtxer_we,
  input  logic [ARCH_WIDTH-1:0]      mtxer_din,
  input  logic [$clog2(CRF_NUM)-1:0] cr_rd_fld,
  output logic [3:0]                 cr_rd_val,
  output logic [4*CRF_NUM-1:0]       cr_all,
  output logic                       XER_SO,
  output logic                       XER_OV,
  output logic                       XER_CA,
  output logic                       pend
);
  localparam int CW = 4*CRF_NUM;
  logic [CW-1:0] a_cr, p_cr, n_cr;
  logic a_so, a_ov, a_ca, p_so, p_ov, p_ca, n_so, n_ov, n_ca;
  logic [CRF_NUM-1:0] sel;
  logic any_we, take;
  logic unused_din;
  // The pending stage holds the complete post-update image, so forwarding is a plain select.
  assign cr_all    = pend ? p_cr : a_cr;
  assign XER_SO    = pend ? p_so : a_so;
  assign XER_OV    = pend ? p_ov : a_ov;
  assign XER_CA    = pend ? p_ca : a_ca;
  assign cr_rd_val = cr_all[{cr_rd_fld, 2'b00} +: 4];
  assign sel        = cr_we ? CRF_NUM'(1) << cr_fld : '0;
  assign any_we     = ca_we | ov_we | cr_we | mtcrf_we | mtxer_we;
  assign take       = any_we & ~flush;
  assign unused_din = ^mtxer_din[ARCH_WIDTH-1:3];
  for (genvar i = 0; i < CRF_NUM; i++) begin : g_fld
    assign n_cr[4*i +: 4] = (mtcrf_we && mtcrf_fxm[i]) ? mtcrf_din[4*i +: 4] : sel[i] ? cr_val : cr_all[4*i +: 4];
  end
  always_comb begin
    n_so = mtxer_we ? mtxer_din[0] : XER_SO | (ov_we & ov_in);
    n_ov = mtxer_we ? mtxer_din[1] : ov_we ? ov_in : XER_OV;
    n_ca = mtxer_we ? mtxer_din[2] : ca_we ? ca_in : XER_CA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_cr <= '0;
      a_so <= 1'b0;
      a_ov <= 1'b0;
      a_ca <= 1'b0;
      p_cr <= '0;
      p_so <= 1'b0;
      p_ov <= 1'b0;
      p_ca <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (pend && !flush) begin
        a_cr <= p_cr;
        a_so <= p_so;
        a_ov <= p_ov;
        a_ca <= p_ca;
      end
      if (take) begin
        p_cr <= n_cr;
        p_so <= n_so;
        p_ov <= n_ov;
        p_ca <= n_ca;
      end
      pend <= take;
    end
  end
endmodule

// File: tb/tb_xer_cr_wb.sv
// tb_xer_cr_wb: directed scenarios plus randomized traffic checked against a field-level reference model
module tb_xer_cr_wb;
  logic clk = 0, rst = 0, flush = 0, ca_we = 0, ca_in = 0, ov_we = 0, ov_in = 0, cr_we = 0;
  logic [2:0] cr_fld = 0, cr_rd_fld = 0;
  logic [3:0] cr_val = 0, cr_rd_val;
  logic mtcrf_we = 0, mtxer_we = 0;
  logic [7:0] mtcrf_fxm = 0;
  logic [31:0] mtcrf_din = 0, mtxer_din = 0, cr_all;
  logic XER_SO, XER_OV, XER_CA, pend;
  int pass_cnt = 0, tot_cnt = 0;
  logic [3:0] v_cr [8], c_cr [8];
  logic v_so, v_ov, v_ca, c_so, c_ov, c_ca, m_pend;

  xer_cr_wb dut (
    .clk(clk), .rst(rst), .flush(flush), .ca_we(ca_we), .ca_in(ca_in), .ov_we(ov_we), .ov_in(ov_in),
    .cr_we(cr_we), .cr_fld(cr_fld), .cr_val(cr_val), .mtcrf_we(mtcrf_we), .mtcrf_fxm(mtcrf_fxm),
    .mtcrf_din(mtcrf_din), .mtxer_we(mtxer_we), .mtxer_din(mtxer_din), .cr_rd_fld(cr_rd_fld),
    .cr_rd_val(cr_rd_val), .cr_all(cr_all), .XER_SO(XER_SO), .XER_OV(XER_OV), .XER_CA(XER_CA), .pend(pend)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = v_cr[i];
    return r;
  endfunction

  // Model: v_* is what a reader sees now, c_* is what is architecturally committed.
  task automatic tick();
    logic any;
    any = ca_we | ov_we | cr_we | mtcrf_we | mtxer_we;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin v_cr[i] = 0; c_cr[i] = 0; end
      {v_so, v_ov, v_ca, c_so, c_ov, c_ca, m_pend} = '0;
    end else if (flush) begin
      v_cr = c_cr;
      {v_so, v_ov, v_ca} = {c_so, c_ov, c_ca};
      m_pend = 0;
    end else begin
      c_cr = v_cr;
      {c_so, c_ov, c_ca} = {v_so, v_ov, v_ca};
      for (int i = 0; i < 8; i++)
        if (mtcrf_we && mtcrf_fxm[i]) v_cr[i] = mtcrf_din[4*i +: 4];
        else if (cr_we && int'(cr_fld) == i) v_cr[i] = cr_val;
      if (mtxer_we) {v_ca, v_ov, v_so} = mtxer_din[2:0];
      else begin
        if (ov_we) begin v_ov = ov_in; v_so = v_so | ov_in; end
        if (ca_we) v_ca = ca_in;
      end
      m_pend = any;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {rst, flush, ca_we, ca_in, ov_we, ov_in, cr_we, mtcrf_we, mtxer_we} = '0;
    cr_fld = 0; cr_val = 0; mtcrf_fxm = 0; mtcrf_din = 0; mtxer_din = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tot_cnt++;
    if ({cr_all, XER_SO, XER_OV, XER_CA, pend} !== 36'h0) $display("FAIL reset: got cr=%h so/ov/ca/pend=%b%b%b%b, want all 0", cr_all, XER_SO, XER_OV, XER_CA, pend);
    else pass_cnt++;
  endtask

  task automatic test_ca_fwd();
    do_reset();
    ca_we = 1; ca_in = 1;
    tot_cnt++;
    if (XER_CA !== 1'b0) $display("FAIL ca_same_cycle: got %b want 0", XER_CA); else pass_cnt++;
    tick();
    idle();
    tot_cnt++;
    if ({XER_CA, pend} !== 2'b11) $display("FAIL ca_next: got ca/pend=%b%b want 11", XER_CA, pend); else pass_cnt++;
    tick();
    tot_cnt++;
    if ({XER_CA, pend} !== 2'b10) $display("FAIL ca_commit: got ca/pend=%b%b want 10", XER_CA, pend); else pass_cnt++;
  endtask

  task automatic test_sticky_so();
    do_reset();
    ov_we = 1; ov_in = 1;
    tick();
    ov_in = 0;
    tick();
    idle();
    tot_cnt++;
    if ({XER_OV, XER_SO} !== 2'b01) $display("FAIL sticky_so: got ov/so=%b%b want 01", XER_OV, XER_SO); else pass_cnt++;
    mtxer_we = 1; mtxer_din = 32'h0;
    tick();
    idle();
    tot_cnt++;
    if ({XER_SO, XER_OV, XER_CA} !== 3'b000) $display("FAIL mtxer_clr: got so/ov/ca=%b%b%b want 000", XER_SO, XER_OV, XER_CA); else pass_cnt++;
    mtxer_we = 1; mtxer_din = 32'hFFFF_FFF6; ca_we = 1; ca_in = 0; ov_we = 1; ov_in = 1;
    tick();
    idle();
    tot_cnt++;
    if ({XER_SO, XER_OV, XER_CA} !== 3'b011) $display("FAIL mtxer_prio: got so/ov/ca=%b%b%b want 011", XER_SO, XER_OV, XER_CA); else pass_cnt++;
  endtask

  task automatic test_cr_merge();
    do_reset();
    cr_we = 1; cr_fld = 2; cr_val = 4'h8; mtcrf_we = 1; mtcrf_fxm = 8'h04; mtcrf_din = 32'h0000_0A00;
    tick();
    idle();
    cr_rd_fld = 2;
    #1;
    tot_cnt++;
    if ({cr_all, cr_rd_val} !== {32'h0000_0A00, 4'hA}) $display("FAIL cr_overlap: got cr=%h rd=%h want 00000a00 a", cr_all, cr_rd_val); else pass_cnt++;
    cr_we = 1; cr_fld = 1; cr_val = 4'h3; mtcrf_we = 1; mtcrf_fxm = 8'h20; mtcrf_din = 32'h0050_0000;
    tick();
    idle();
    tot_cnt++;
    if (cr_all !== 32'h0050_0A30) $display("FAIL cr_disjoint: got %h want 00500a30", cr_all); else pass_cnt++;
    mtcrf_we = 1; mtcrf_fxm = 8'h00; mtcrf_din = 32'hFFFF_FFFF; ca_we = 1; ca_in = 1;
    tick();
    idle();
    tot_cnt++;
    if ({cr_all, pend, XER_CA} !== {32'h0050_0A30, 2'b11}) $display("FAIL fxm_zero: got cr=%h pend/ca=%b%b want 00500a30 11", cr_all, pend, XER_CA); else pass_cnt++;
    tick();
    tot_cnt++;
    if (pend !== 1'b0) $display("FAIL no_we_idle: got pend=%b want 0", pend); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    cr_we = 1; cr_fld = 0; cr_val = 4'h2; cr_rd_fld = 0;
    tick();
    idle();
    flush = 1; ca_we = 1; ca_in = 1;
    #1;
    tot_cnt++;
    if (cr_rd_val !== 4'h2) $display("FAIL flush_fwd: got %h want 2", cr_rd_val); else pass_cnt++;
    tick();
    idle();
    tot_cnt++;
    if ({cr_rd_val, cr_all, pend, XER_CA} !== 38'h0) $display("FAIL flush_drop: got rd=%h cr=%h pend/ca=%b%b want 0", cr_rd_val, cr_all, pend, XER_CA); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq;
    seq = 3'b101;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ca_we = 1; ca_in = seq[k];
      tick();
      tot_cnt++;
      if ({XER_CA, pend} !== {seq[k], 1'b1}) $display("FAIL b2b_%0d: got ca/pend=%b%b want %b1", k, XER_CA, pend, seq[k]); else pass_cnt++;
    end
    idle();
    ov_we = 1; ov_in = 1;
    tick();
    ov_in = 0;
    tick();
    mtxer_we = 0; ov_we = 0; cr_we = 1; cr_fld = 7; cr_val = 4'h5;
    tick();
    idle();
    tick();
    tot_cnt++;
    if ({XER_SO, XER_OV, cr_all[31:28]} !== {2'b10, 4'h5}) $display("FAIL b2b_so: got so/ov=%b%b f7=%h want 10 5", XER_SO, XER_OV, cr_all[31:28]); else pass_cnt++;
  endtask

  task automatic test_rst_pending();
    do_reset();
    cr_we = 1; cr_fld = 0; cr_val = 4'hF; ca_we = 1; ca_in = 1;
    tick();
    idle();
    tot_cnt++;
    if ({cr_all, pend} !== {32'hF, 1'b1}) $display("FAIL rst_pre: got cr=%h pend=%b want 0000000f 1", cr_all, pend); else pass_cnt++;
    rst = 1; flush = 1; mtxer_we = 1; mtxer_din = 32'h7;
    tick();
    idle();
    tot_cnt++;
    if ({cr_all, XER_SO, XER_OV, XER_CA, pend} !== 36'h0) $display("FAIL rst_pend: got cr=%h so/ov/ca/pend=%b%b%b%b want 0", cr_all, XER_SO, XER_OV, XER_CA, pend); else pass_cnt++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      flush = ($urandom_range(7) == 0);
      {ca_we, ov_we, cr_we, mtcrf_we, mtxer_we} = 5'($urandom) & 5'($urandom);
      {ca_in, ov_in} = 2'($urandom);
      cr_fld = 3'($urandom); cr_val = 4'($urandom); cr_rd_fld = 3'($urandom);
      mtcrf_fxm = 8'($urandom) & 8'($urandom); mtcrf_din = $urandom;
      mtxer_din = $urandom;
      #1;
      tot_cnt++;
      if ({cr_all, cr_rd_val, XER_SO, XER_OV, XER_CA, pend} !== {img(), v_cr[cr_rd_fld], v_so, v_ov, v_ca, m_pend})
        $display("FAIL rand_%0d: got cr=%h rd=%h so/ov/ca/pend=%b%b%b%b want cr=%h rd=%h %b%b%b%b", n, cr_all, cr_rd_val,
                 XER_SO, XER_OV, XER_CA, pend, img(), v_cr[cr_rd_fld], v_so, v_ov, v_ca, m_pend);
      else pass_cnt++;
      tick();
    end
    idle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_ca_fwd();
    test_sticky_so();
    test_cr_merge();
    test_flush();
    test_back_to_back();
    test_rst_pending();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
